// File: rtl/mult_pkg.sv
// Shared constants, state encoding and saturation helpers for the multiplier
// datapath and its accumulation stage.
package mult_pkg;

    localparam int MAX_PRECISION = 16;
    localparam int PROD_WIDTH    = 2 * MAX_PRECISION;
    localparam int ACC_WIDTH_DEF = 40;
    localparam int SAT_W         = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        PUSH = 2'd2
    } state_t;

    // Returned 64 bits wide; callers truncate to their accumulator width.
    function automatic logic [SAT_W-1:0] sat_max(input int w);
        return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    endfunction

    function automatic logic [SAT_W-1:0] sat_min(input int w);
        return SAT_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/mult_acc_drain_if.sv
// Product stream in, result stream out, plus the issue credit back to the
// operand issuer.
interface mult_acc_drain_if
    import mult_pkg::*;
#(
    parameter int PROD_W = PROD_WIDTH,
    parameter int ACC_W  = ACC_WIDTH_DEF
);
    logic              prod_valid;
    logic [PROD_W-1:0] prod;
    logic              in_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_data;
    logic              out_ovf;
    logic              out_ready;

    modport slave (
        input  prod_valid, prod, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );

    modport master (
        output prod_valid, prod, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mult_acc_fifo.sv
// Small synchronous result FIFO; the head entry is presented directly from
// storage so out_data is valid in the same cycle out_valid rises.
module mult_acc_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic               clk_gate,
    input  logic               rst_n,
    input  logic               push,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               pop,
    output logic [WIDTH-1:0]   rdata,
    output logic               full,
    output logic               empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; the empty flag masks stale entries, so
    // clearing the array would only add reset fan-out.
    always_ff @(posedge clk_gate) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk_gate or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mult_acc_drain.sv
// Accumulates cfg_len consecutive multiplier products into one (optionally
// saturating) dot-product result and queues it for a valid/ready consumer.
module mult_acc_drain
    import mult_pkg::*;
#(
    parameter int MAX_PRECISION = mult_pkg::MAX_PRECISION,
    parameter int ACC_WIDTH     = ACC_WIDTH_DEF,
    parameter int LEN_WIDTH     = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                 clk_gate,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic                 cfg_sat,
    input  logic                 cfg_auto,
    input  logic                 err_clr,
    output logic                 busy,
    output logic                 proto_err,
    mult_acc_drain_if.slave      bus
);
    localparam int PW  = 2 * MAX_PRECISION;
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

    state_t                       state, next_state;
    logic signed [ACC_WIDTH-1:0]  acc, prod_ext, sum, acc_nxt;
    logic [LEN_WIDTH-1:0]         cnt, len_q, issue_cnt;
    logic                         ovf, sat_q, auto_q, last_issued;
    logic                         ovf_now, accept, last_prod, enter_acc, err_set;
    logic                         fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FCW-1:0]               fifo_count;
    logic [FCW:0]                 occupancy;

    always_comb begin
        prod_ext = ACC_WIDTH'(signed'(bus.prod[PW-1:0]));
        sum      = acc + prod_ext;
        ovf_now  = (acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
        acc_nxt  = sum;
        if (ovf_now && sat_q) acc_nxt = acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end

    assign accept    = (state == ACC) && bus.prod_valid;
    assign last_prod = accept && (cnt == len_q - LEN_WIDTH'(1));
    assign enter_acc = (state != ACC) && (next_state == ACC);
    assign fifo_push = (state == PUSH) && !fifo_full;
    assign fifo_pop  = bus.out_valid && bus.out_ready;
    assign err_set   = (bus.prod_valid && state != ACC) || (state == PUSH && fifo_full);
    assign busy      = (state != IDLE);

    // One slot of headroom absorbs the product still inside the multiplier.
    assign occupancy    = {1'b0, fifo_count} + (FCW+1)'(state == PUSH);
    assign bus.in_ready = (state == ACC) && !last_issued &&
                          (occupancy < (FCW+1)'(FIFO_DEPTH - 1));

    // NOTE: default next_state first so every path assigns it and no latch forms.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACC;
            ACC:     if (last_prod) next_state = PUSH;
            PUSH:    next_state = auto_q ? ACC : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk_gate or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk_gate or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            len_q       <= LEN_WIDTH'(1);
            sat_q       <= 1'b0;
            auto_q      <= 1'b0;
            issue_cnt   <= '0;
            last_issued <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    len_q  <= (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
                    sat_q  <= cfg_sat;
                    auto_q <= cfg_auto;
                    acc    <= '0;
                    cnt    <= '0;
                    ovf    <= 1'b0;
                end
                ACC: if (accept) begin
                    acc <= acc_nxt;
                    cnt <= cnt + LEN_WIDTH'(1);
                    ovf <= ovf | ovf_now;
                end
                PUSH: if (auto_q) begin
                    acc <= '0;
                    cnt <= '0;
                    ovf <= 1'b0;
                end
                default: ;
            endcase

            // Each in_ready cycle is one granted launch toward the current vector.
            if (enter_acc) begin
                issue_cnt   <= '0;
                last_issued <= 1'b0;
            end else if (bus.in_ready) begin
                issue_cnt <= issue_cnt + LEN_WIDTH'(1);
                if (issue_cnt == len_q - LEN_WIDTH'(1)) last_issued <= 1'b1;
            end

            proto_err <= err_set | (proto_err & ~err_clr);
        end
    end

    mult_acc_fifo #(
        .WIDTH (ACC_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_gate (clk_gate),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .wdata    ({ovf, acc}),
        .pop      (fifo_pop),
        .rdata    ({bus.out_ovf, bus.out_data}),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign bus.out_valid = !fifo_empty;

endmodule

// File: tb/tb_mult_acc_drain.sv
// Directed bench for mult_acc_drain: vector table plus hand-written sequences
// for protocol errors, backpressure and mid-vector reset.
module tb_mult_acc_drain;
    import mult_pkg::*;

    localparam int AW    = 32;
    localparam int LW    = 8;
    localparam int DEPTH = 4;

    logic          clk_gate = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic [LW-1:0] cfg_len  = '0;
    logic          cfg_sat  = 1'b0;
    logic          cfg_auto = 1'b0;
    logic          err_clr  = 1'b0;
    logic          busy, proto_err;

    mult_acc_drain_if #(.PROD_W(32), .ACC_W(AW)) bus ();

    mult_acc_drain #(
        .MAX_PRECISION (16),
        .ACC_WIDTH     (AW),
        .LEN_WIDTH     (LW),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk_gate  (clk_gate),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_len   (cfg_len),
        .cfg_sat   (cfg_sat),
        .cfg_auto  (cfg_auto),
        .err_clr   (err_clr),
        .busy      (busy),
        .proto_err (proto_err),
        .bus       (bus.slave)
    );

    always #5 clk_gate = ~clk_gate;

    typedef struct {
        string          name;
        logic [LW-1:0]  len;
        logic           sat;
        int             n;
        logic [3:0][31:0] p;
        logic [31:0]    exp_data;
        logic           exp_ovf;
    } vec_t;

    vec_t vec_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_gate);
        #1;
    endtask

    task automatic add_vec(input string nm, input logic [LW-1:0] len, input logic sat,
                           input int n, input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] p2, input logic [31:0] p3,
                           input logic [31:0] exp_data, input logic exp_ovf);
        vec_t v;
        v.name = nm; v.len = len; v.sat = sat; v.n = n;
        v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
        v.exp_data = exp_data; v.exp_ovf = exp_ovf;
        vec_q.push_back(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, ".out_data"},  64'(bus.out_data),  64'd0);
        check({tag, ".out_ovf"},   64'(bus.out_ovf),   64'd0);
        check({tag, ".in_ready"},  64'(bus.in_ready),  64'd0);
        check({tag, ".busy"},      64'(busy),          64'd0);
        check({tag, ".proto_err"}, 64'(proto_err),     64'd0);
    endtask

    task automatic start_vec(input logic [LW-1:0] len, input logic sat, input logic auto_mode);
        start = 1'b1; cfg_len = len; cfg_sat = sat; cfg_auto = auto_mode;
        tick();
        start = 1'b0;
    endtask

    task automatic send_one(input logic [31:0] value);
        bus.prod_valid = 1'b1;
        bus.prod       = value;
        tick();
        bus.prod_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        start_vec(v.len, v.sat, 1'b0);
        check({v.name, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < v.n; i++) begin
            bus.prod_valid = 1'b1;
            bus.prod       = v.p[i];
            tick();
        end
        bus.prod_valid = 1'b0;
        check({v.name, ".push_cycle_valid"}, 64'(bus.out_valid), 64'd0);
        check({v.name, ".push_cycle_busy"},  64'(busy),          64'd1);
        tick();
        check({v.name, ".out_valid"}, 64'(bus.out_valid), 64'd1);
        check({v.name, ".out_data"},  64'(bus.out_data),  64'(v.exp_data));
        check({v.name, ".out_ovf"},   64'(bus.out_ovf),   64'(v.exp_ovf));
        check({v.name, ".idle"},      64'(busy),          64'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({v.name, ".drained"},   64'(bus.out_valid), 64'd0);
        check({v.name, ".proto_err"}, 64'(proto_err),     64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ir_prev;
        int          issued;
        logic [31:0] got[$];

        bus.prod_valid = 1'b0;
        bus.prod       = '0;
        bus.out_ready  = 1'b0;

        add_vec("basic4",      8'd4, 1'b0, 4, 32'd3, 32'hFFFF_FFFB, 32'd7, 32'd10,
                32'd15, 1'b0);
        add_vec("sat_pos",     8'd2, 1'b1, 2, 32'h7FFF_0000, 32'h7FFF_0000, 32'd0, 32'd0,
                32'h7FFF_FFFF, 1'b1);
        add_vec("wrap_pos",    8'd2, 1'b0, 2, 32'h7FFF_0000, 32'h7FFF_0000, 32'd0, 32'd0,
                32'hFFFE_0000, 1'b1);
        add_vec("sat_neg",     8'd2, 1'b1, 2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0,
                32'h8000_0000, 1'b1);
        add_vec("len0_as_1",   8'd0, 1'b0, 1, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0,
                32'hFFFF_FFF9, 1'b0);
        add_vec("wrap_twice",  8'd3, 1'b0, 3, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0,
                32'h7FFF_FFFF, 1'b1);
        add_vec("clamp_then",  8'd3, 1'b1, 3, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0,
                32'h7FFF_FFFE, 1'b1);

        // Reset values, both while held and after release.
        repeat (2) tick();
        check_reset_outputs("rst_held");
        rst_n = 1'b1;
        tick();
        check_reset_outputs("rst_released");

        foreach (vec_q[i]) run_vec(vec_q[i]);

        // Product in IDLE is dropped; err_clr clears, but loses to a new error.
        send_one(32'd55);
        check("idle_drop.proto_err", 64'(proto_err), 64'd1);
        check("idle_drop.out_valid", 64'(bus.out_valid), 64'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr.proto_err", 64'(proto_err), 64'd0);
        bus.prod_valid = 1'b1; err_clr = 1'b1;
        tick();
        bus.prod_valid = 1'b0; err_clr = 1'b0;
        check("err_clr_vs_new.proto_err", 64'(proto_err), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // start during ACC must not relatch len; a PUSH-cycle product is dropped.
        start_vec(8'd2, 1'b0, 1'b0);
        send_one(32'd5);
        start = 1'b1; cfg_len = 8'd5;
        send_one(32'd6);
        start = 1'b0;
        check("restart.push_busy", 64'(busy), 64'd1);
        send_one(32'd1000);
        check("restart.out_valid", 64'(bus.out_valid), 64'd1);
        check("restart.out_data",  64'(bus.out_data),  64'd11);
        check("push_drop.proto_err", 64'(proto_err), 64'd1);
        check("restart.idle", 64'(busy), 64'd0);
        bus.out_ready = 1'b1; err_clr = 1'b1;
        tick();
        bus.out_ready = 1'b0; err_clr = 1'b0;

        // Backpressure: an issuer that launches on in_ready, product one cycle later.
        start_vec(8'd1, 1'b0, 1'b1);
        issued = 0; ir_prev = 1'b0;
        for (int c = 0; c < 15; c++) begin
            bus.prod_valid = ir_prev && (issued < 4);
            if (bus.prod_valid) begin
                bus.prod = 32'(100 + issued);
                issued++;
            end
            ir_prev = bus.in_ready;
            tick();
        end
        bus.prod_valid = 1'b0;
        check("bp.issued_before_release", 64'(issued), 64'd3);
        check("bp.in_ready_low", 64'(bus.in_ready), 64'd0);
        check("bp.head_valid",   64'(bus.out_valid), 64'd1);
        check("bp.head_data",    64'(bus.out_data),  64'd100);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            bus.prod_valid = ir_prev && (issued < 4);
            if (bus.prod_valid) begin
                bus.prod = 32'(100 + issued);
                issued++;
            end
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            ir_prev = bus.in_ready;
            tick();
        end
        bus.prod_valid = 1'b0;
        bus.out_ready  = 1'b0;
        check("bp.drain_count", 64'(got.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("bp.drain[%0d]", k),
                  (k < got.size()) ? 64'(got[k]) : 64'hDEAD, 64'(100 + k));
        check("bp.proto_err", 64'(proto_err), 64'd0);

        // Mid-vector reset with two results queued.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        start_vec(8'd1, 1'b0, 1'b0);
        send_one(32'd21);
        tick();
        start_vec(8'd1, 1'b0, 1'b0);
        send_one(32'd22);
        tick();
        check("mid.queued_head", 64'(bus.out_data), 64'd21);
        start_vec(8'd4, 1'b0, 1'b0);
        send_one(32'd1);
        send_one(32'd2);
        check("mid.busy_before_reset", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst_async");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("mid_rst_after");
        start_vec(8'd1, 1'b0, 1'b0);
        send_one(32'd9);
        tick();
        check("post_rst.out_valid", 64'(bus.out_valid), 64'd1);
        check("post_rst.out_data",  64'(bus.out_data),  64'd9);
        check("post_rst.out_ovf",   64'(bus.out_ovf),   64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
